spram_arbiter: RTL
==================

# spram_arbiter

Two-port Wishbone (pipelined) arbiter that shares one single-port 32-bit synchronous RAM (1-cycle read latency, byte write enables) between two requesters, typically the Ibex instruction and data buses in the simulation top. It grants at most one access per cycle, drives the RAM's address, chip-enable, byte-enable and write-data pins, and returns the read data with a registered acknowledge one cycle later. Back-to-back accesses sustain one transfer per cycle.

## Interface
- `size`, default `'h80`: RAM size in bytes; must match the RAM instance.
- `addr_width`, default `$clog2(size) - 2`: RAM word-address width.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cyc_i[n]`, `stb_i[n]`  in  1 each  (n = 0,1) Wishbone cycle / strobe.
- `we_i[n]`  in  1  write request.
- `sel_i[n]`  in  4  byte selects.
- `adr_i[n]`  in  32  byte address.
- `dat_i[n]`  in  32  write data.
- `dat_o[n]`  out  32  read data.
- `ack_o[n]`  out  1  acknowledge.
- `stall_o[n]`  out  1  pipelined-Wishbone stall.
- `ram_addr`  out  addr_width  RAM word address.
- `ram_ce`  out  1  RAM chip enable.
- `ram_we`  out  4  RAM byte write enables.
- `ram_d`  out  32  RAM write data.
- `ram_q`  in  32  RAM read data (valid the cycle after `ram_ce`).

## Operation
- Port n requests in a cycle when `cyc_i[n] & stb_i[n]`.
- The arbiter grants at most one requesting port per cycle, combinationally in the same cycle.
- Granted port: `ram_ce=1`, `ram_addr=adr_i[n][addr_width+1:2]`, `ram_we=sel_i[n] & {4{we_i[n]}}`, `ram_d=dat_i[n]`.
- No grant: `ram_ce=0`, `ram_we=0`; `ram_addr` and `ram_d` are don't-care.
- Address bits above `addr_width+1` are ignored, so out-of-range addresses wrap. Bits [1:0] are ignored.
- `stall_o[n] = cyc_i[n] & stb_i[n] & ~grant[n]`.
- State:
  - `ack_q[1:0]`: set for the port granted this cycle, cleared otherwise.
  - `last[0]`: port most recently granted; reset value 1, so port 0 wins the first contention.
- `ack_o[n] = ack_q[n] & cyc_i[n]`. Dropping `cyc` aborts delivery of an in-flight acknowledge; a write already issued stays committed.
- `dat_o[n] = ram_q` for both ports, qualified only by `ack_o[n]`. Writes also return `ram_q`, which is the RAM's old or new word and is don't-care.
- Arbitration with both ports requesting: grant `~last`, then update `last` to the granted port. With one requester, grant it; `last` still updates.

## Timing
- Cycle N: request is accepted (`stall_o=0`) and RAM pins are driven.
- Cycle N+1: `ack_o=1` and `dat_o` is valid.
- Latency is 1 cycle; throughput is 1 access per cycle, shared between the ports.
- Read-after-write to the same address in consecutive cycles returns the newly written bytes.
- Reset values: `ack_q=0` and `last=1`, so `ack_o=0`. `stall_o` and the `ram_*` pins follow the combinational rules; `ram_ce=0` while `rst` is asserted (requests masked).
- Reset asserted mid-transfer: any pending ack is discarded immediately, with no ack after reset release.
- `stall_o` is combinational from `cyc_i`, `stb_i` and `last`. Masters must not use it to form `stb` combinationally.

## Configuration
- `SPRAM_ARB_RR_EN` defined: round-robin arbitration as above.
- `SPRAM_ARB_RR_EN` undefined: fixed priority, port 0 always wins contention.
  - `last` is not implemented.
  - Port 1 may starve while port 0 requests every cycle.

## Test plan
- Reset: hold `rst=1` with both ports requesting → `ack_o=00`, `ram_ce=0`. Release → first grant goes to port 0.
- Single-port write then read: port 0 writes `0xDEADBEEF` to `0x10` with `sel=4'hF`, then reads `0x10` in the next cycle → acks on consecutive cycles, read `dat_o[0]=0xDEADBEEF`.
- Byte enables: write `0x11223344` with `sel=4'b0101` over `0xFFFFFFFF` → read returns `0xFF22FF44`.
- Contention, round-robin build: both ports read every cycle for 6 cycles → grants alternate 0,1,0,1,0,1 and each port gets 3 acks with the correct data. Fixed-priority build: port 0 gets 6 acks, port 1 stays stalled.
- Abort: port 1 is granted in cycle N and drops `cyc` in N+1 → `ack_o[1]=0` in N+1, and port 0's ack is unaffected.
- Address wrap (`size='h80`): write to `0x84`, then read `0x04` → same word returned.

Source files
------------

// File: rtl/spram_arbiter_if.sv
// Bundle of the two pipelined-Wishbone requester ports that share the RAM.
// Index 0 and 1 of each member belong to port 0 and port 1 respectively.
interface spram_arbiter_if;
    logic [1:0]       cyc;
    logic [1:0]       stb;
    logic [1:0]       we;
    logic [1:0][3:0]  sel;
    logic [1:0][31:0] adr;
    logic [1:0][31:0] wdat;
    logic [1:0][31:0] rdat;
    logic [1:0]       ack;
    logic [1:0]       stall;

    modport master (
        output cyc, stb, we, sel, adr, wdat,
        input  rdat, ack, stall
    );

    modport slave (
        input  cyc, stb, we, sel, adr, wdat,
        output rdat, ack, stall
    );
endinterface

// File: rtl/spram_arbiter.sv
// Shares one single-port synchronous RAM between two pipelined-Wishbone ports.
// Define SPRAM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module spram_arbiter #(
    parameter int size       = 'h80,
    parameter int addr_width = $clog2(size) - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    spram_arbiter_if.slave        bus,
    output logic [addr_width-1:0] ram_addr,
    output logic                  ram_ce,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_d,
    input  logic [31:0]           ram_q
);
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] ack_reg;
    logic       gsel;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // Requests are masked during reset so the RAM is never enabled then.
            assign req[gi]       = bus.cyc[gi] & bus.stb[gi] & ~rst;
            assign bus.stall[gi] = bus.cyc[gi] & bus.stb[gi] & ~grant[gi];
            assign bus.ack[gi]   = ack_reg[gi] & bus.cyc[gi];
            assign bus.rdat[gi]  = ram_q;
        end
    endgenerate

`ifdef SPRAM_ARB_RR_EN
    logic last_reg;

    always_comb begin
        grant[0] = req[0] & (~req[1] | last_reg);
        grant[1] = req[1] & ~grant[0];
    end

    // last_reg remembers which port won most recently; reset to 1 so port 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (|grant) begin
            last_reg <= grant[1];
        end
    end
`else
    always_comb begin
        grant[0] = req[0];
        grant[1] = req[1] & ~req[0];
    end
`endif

    assign gsel     = grant[1];
    assign ram_ce   = |grant;
    assign ram_addr = bus.adr[gsel][addr_width+1:2];
    assign ram_we   = ram_ce ? (bus.sel[gsel] & {4{bus.we[gsel]}}) : 4'b0000;
    assign ram_d    = bus.wdat[gsel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_reg <= 2'b00;
        end else begin
            ack_reg <= grant;
        end
    end
endmodule
